// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter that pulls bytes from a non-FWFT TX FIFO (1-cycle read
// latency) and serialises them onto the board pin, LSB first, with an
// optional parity bit. One FIFO read is issued per frame, and only when
// the FIFO is non-empty and the line is idle.
//
// Frame on the pin: start(0), D0..D7, [parity], stop(1); each bit lasts
// CLKS_PER_BIT = CLK_FREQ / BAUD_RATE clocks (must be >= 2).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tx_en      in   level enable, only looked at while idle
//   rd_empty   in   FIFO empty flag
//   rd_req     out  FIFO read request, one registered pulse per frame
//   rd_data    in   FIFO read data, valid the cycle after rd_req is sampled
//   txd        out  serial output, idle high, driven from a flop
//   tx_busy    out  high whenever the transmitter is not idle
//   frame_done out  one-cycle pulse during the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       rd_empty,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       txd,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  // Parity bit for a data byte: even parity unless odd is selected.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic             txd_q;
  logic             rd_req_q;
  logic             tx_busy_q;
  logic             frame_done_q;

  logic             bit_end_s;
  logic             bit_pre_end_s;

  assign bit_end_s     = (baud_cnt_q == CNT_LAST);
  assign bit_pre_end_s = (baud_cnt_q == CNT_PRE_LAST);

  // Transmit FSM: sequencing, baud/bit counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      baud_cnt_q   <= CNT_ZERO;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      txd_q        <= 1'b1;
      rd_req_q     <= 1'b0;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // Pulse outputs default low; only the states below raise them.
      rd_req_q     <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          txd_q      <= 1'b1;
          baud_cnt_q <= CNT_ZERO;
          bit_idx_q  <= 3'd0;
          if (tx_en && !rd_empty) begin
            rd_req_q  <= 1'b1;
            tx_busy_q <= 1'b1;
            state_q   <= S_REQ;
          end else begin
            tx_busy_q <= 1'b0;
          end
        end

        // FIFO samples rd_req at the edge that closes this state; the empty
        // flag is deliberately not looked at again.
        S_REQ: begin
          baud_cnt_q <= CNT_ZERO;
          state_q    <= S_WAIT;
        end

        // Read data is valid now; the start bit goes out on the same edge
        // that captures it.
        S_WAIT: begin
          shift_q    <= rd_data;
          parity_q   <= calc_parity(rd_data, PARITY_ODD);
          baud_cnt_q <= CNT_ZERO;
          bit_idx_q  <= 3'd0;
          txd_q      <= 1'b0;
          state_q    <= S_START;
        end

        S_START: begin
          if (bit_end_s) begin
            baud_cnt_q <= CNT_ZERO;
            txd_q      <= shift_q[0];
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_ONE;
          end
        end

        // txd is loaded one bit ahead from shift_q[1] so the pin changes on
        // the boundary edge itself.
        S_DATA: begin
          if (bit_end_s) begin
            baud_cnt_q <= CNT_ZERO;
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN) begin
                txd_q   <= parity_q;
                state_q <= S_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_ONE;
          end
        end

        S_PARITY: begin
          if (bit_end_s) begin
            baud_cnt_q <= CNT_ZERO;
            txd_q      <= 1'b1;
            state_q    <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_ONE;
          end
        end

        // frame_done is set one count early so that, being registered, it is
        // high exactly during the last stop-bit cycle.
        S_STOP: begin
          txd_q <= 1'b1;
          if (bit_end_s) begin
            baud_cnt_q <= CNT_ZERO;
            tx_busy_q  <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_ONE;
            if (bit_pre_end_s) begin
              frame_done_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          baud_cnt_q <= CNT_ZERO;
          bit_idx_q  <= 3'd0;
          txd_q      <= 1'b1;
          tx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_req     = rd_req_q;
  assign txd        = txd_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Three transmitters share one clock:
//   dut0: 4 clocks/bit, no parity
//   dut1: 4 clocks/bit, even parity
//   dut2: 3 clocks/bit, odd parity
// Each has its own behavioural FIFO (array + pointers, 1-cycle read latency).
// Frames are checked cycle by cycle against a reference frame built from
// the byte value, plus table-driven parity/length vectors and hand-written
// sequences for reset, enable and back-to-back corner cases.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n;
  logic [2:0] tx_en;
  logic [2:0] rd_empty;
  logic [2:0] rd_req;
  logic [2:0] txd;
  logic [2:0] tx_busy;
  logic [2:0] frame_done;
  logic [7:0] rd_data [3];

  logic [7:0] fmem [3][64];
  int         wr_ptr [3];
  int         rd_ptr [3];
  int         rd_req_cnt [3];
  logic [2:0] req_prev;
  int         underflow_cnt;
  int         overlap_cnt;
  int         wide_req_cnt;

  int checks;
  int errors;

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD_RATE(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .tx_en(tx_en[0]), .rd_empty(rd_empty[0]),
    .rd_req(rd_req[0]), .rd_data(rd_data[0]), .txd(txd[0]),
    .tx_busy(tx_busy[0]), .frame_done(frame_done[0]));

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD_RATE(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .tx_en(tx_en[1]), .rd_empty(rd_empty[1]),
    .rd_req(rd_req[1]), .rd_data(rd_data[1]), .txd(txd[1]),
    .tx_busy(tx_busy[1]), .frame_done(frame_done[1]));

  uart_tx_fifo #(.CLK_FREQ(9), .BAUD_RATE(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .tx_en(tx_en[2]), .rd_empty(rd_empty[2]),
    .rd_req(rd_req[2]), .rd_data(rd_data[2]), .txd(txd[2]),
    .tx_busy(tx_busy[2]), .frame_done(frame_done[2]));

  assign rd_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign rd_empty[1] = (wr_ptr[1] == rd_ptr[1]);
  assign rd_empty[2] = (wr_ptr[2] == rd_ptr[2]);

  // FIFO read side plus protocol monitors on rd_req.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      req_prev[g] <= rd_req[g];
      if (rd_req[g] === 1'b1) begin
        rd_req_cnt[g] <= rd_req_cnt[g] + 1;
        if (req_prev[g] === 1'b1) wide_req_cnt <= wide_req_cnt + 1;
        if (frame_done[g] === 1'b1) overlap_cnt <= overlap_cnt + 1;
        if (wr_ptr[g] == rd_ptr[g]) begin
          underflow_cnt <= underflow_cnt + 1;
        end else begin
          rd_data[g] <= fmem[g][rd_ptr[g] % 64];
          rd_ptr[g]  <= rd_ptr[g] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    fmem[g][wr_ptr[g] % 64] = b;
    wr_ptr[g] = wr_ptr[g] + 1;
  endtask

  function automatic int cpb_of(input int g);
    return (g == 2) ? 3 : 4;
  endfunction

  function automatic bit pen_of(input int g);
    return (g != 0);
  endfunction

  function automatic bit podd_of(input int g);
    return (g == 2);
  endfunction

  // Reference line level for bit slot idx of a frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input bit pen, input bit podd, input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pen && idx == 9) return podd ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    return 1'b1;
  endfunction

  // Wait for a start bit, then follow the whole frame on txd.
  task automatic run_frame(input int g, input logic [7:0] exp, output int gap,
                           output logic pbit, output int len);
    int cpb, nb, done_cnt, bad;
    bit seen;
    logic [7:0] dec;
    cpb = cpb_of(g);
    nb = pen_of(g) ? 11 : 10;
    gap = 0; seen = 1'b0; pbit = 1'b0; len = -1; dec = 8'h00; done_cnt = 0; bad = 0;
    while (!seen && gap < 400) begin
      @(negedge clk);
      if (txd[g] === 1'b0) seen = 1'b1;
      else gap++;
    end
    check("start_seen", 32'(seen), 32'd1);
    if (!seen) return;
    for (int c = 0; c < nb * cpb; c++) begin
      if (c > 0) @(negedge clk);
      if (txd[g] !== frame_bit(exp, pen_of(g), podd_of(g), c / cpb)) bad++;
      if (c % cpb == cpb / 2) begin
        if (c / cpb >= 1 && c / cpb <= 8) dec[c / cpb - 1] = txd[g];
        if (c / cpb == 9 && pen_of(g)) pbit = txd[g];
      end
      if (frame_done[g] === 1'b1) begin
        done_cnt++;
        len = c + 1;
      end
      if (c % cpb == cpb - 1) begin
        check("txd_bit_slot", bad, 0);
        bad = 0;
      end
    end
    check("frame_byte", dec, exp);
    check("frame_done_pulses", done_cnt, 1);
    check("frame_len", len, nb * cpb);
  endtask

  typedef struct {
    int         g;
    logic [7:0] data;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   gap, len, r0, w;
    logic pbit;
    bit   ok1, ok2, ok3;
    logic [7:0] rb [4];

    vecs[0] = '{1, 8'h07, 1'b1, 44};
    vecs[1] = '{2, 8'h07, 1'b0, 33};
    vecs[2] = '{1, 8'h00, 1'b0, 44};
    vecs[3] = '{2, 8'h00, 1'b1, 33};
    vecs[4] = '{1, 8'hFF, 1'b0, 44};
    vecs[5] = '{2, 8'hFF, 1'b1, 33};
    vecs[6] = '{1, 8'h80, 1'b1, 44};
    vecs[7] = '{2, 8'h80, 1'b0, 33};

    // Reset with 0xA5 already queued
    rst_n = 3'b000;
    tx_en = 3'b111;
    push(0, 8'hA5);
    ok1 = 1'b1; ok2 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) ok1 = 1'b0;
      if (rd_req[0] !== 1'b0) ok2 = 1'b0;
    end
    check("rst_txd_high", 32'(ok1), 32'd1);
    check("rst_rd_req_low", 32'(ok2), 32'd1);
    check("rst_busy_low", 32'(tx_busy[0]), 32'd0);
    check("rst_done_low", 32'(frame_done[0]), 32'd0);
    rst_n = 3'b111;
    run_frame(0, 8'hA5, gap, pbit, len);
    repeat (5) @(negedge clk);
    check("a5_rd_req_pulses", rd_req_cnt[0], 1);

    // Parity / frame length vectors
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].g, vecs[i].data);
      run_frame(vecs[i].g, vecs[i].data, gap, pbit, len);
      check("vec_parity_bit", 32'(pbit), 32'(vecs[i].exp_par));
      check("vec_frame_len", len, vecs[i].exp_len);
      repeat (3) @(negedge clk);
    end

    // Back-to-back 0x00, 0xFF, 0x55
    tx_en[0] = 1'b0;
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
    r0 = rd_req_cnt[0];
    tx_en[0] = 1'b1;
    run_frame(0, 8'h00, gap, pbit, len);
    run_frame(0, 8'hFF, gap, pbit, len);
    check("b2b_gap_1", gap, 3);
    run_frame(0, 8'h55, gap, pbit, len);
    check("b2b_gap_2", gap, 3);
    repeat (10) @(negedge clk);
    check("b2b_rd_req_pulses", rd_req_cnt[0] - r0, 3);

    // Random back-to-back on the even-parity transmitter
    tx_en[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rb[i] = 8'($urandom);
      push(1, rb[i]);
    end
    tx_en[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_frame(1, rb[i], gap, pbit, len);
      if (i > 0) check("rand_b2b_gap", gap, 3);
    end

    // Random isolated frames on the odd-parity transmitter
    for (int i = 0; i < 6; i++) begin
      rb[0] = 8'($urandom);
      push(2, rb[0]);
      run_frame(2, rb[0], gap, pbit, len);
      w = int'($urandom_range(0, 7));
      repeat (w) @(negedge clk);
    end

    // Empty FIFO for 1000 cycles with enable high
    ok1 = 1'b1; ok2 = 1'b1; ok3 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd_req[0] !== 1'b0) ok1 = 1'b0;
      if (txd[0] !== 1'b1) ok2 = 1'b0;
      if (tx_busy[0] !== 1'b0) ok3 = 1'b0;
    end
    check("empty_no_rd_req", 32'(ok1), 32'd1);
    check("empty_txd_high", 32'(ok2), 32'd1);
    check("empty_not_busy", 32'(ok3), 32'd1);

    // tx_en dropped mid-frame with two bytes queued
    tx_en[0] = 1'b0;
    push(0, 8'hC3); push(0, 8'h5A);
    r0 = rd_req_cnt[0];
    tx_en[0] = 1'b1;
    ok1 = 1'b0;
    for (int i = 0; i < 20 && !ok1; i++) begin
      @(negedge clk);
      if (tx_busy[0] === 1'b1) ok1 = 1'b1;
    end
    check("en_drop_busy_seen", 32'(ok1), 32'd1);
    tx_en[0] = 1'b0;
    run_frame(0, 8'hC3, gap, pbit, len);
    ok2 = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || tx_busy[0] !== 1'b0) ok2 = 1'b0;
    end
    check("en_drop_line_idle", 32'(ok2), 32'd1);
    check("en_drop_one_req", rd_req_cnt[0] - r0, 1);
    tx_en[0] = 1'b1;
    run_frame(0, 8'h5A, gap, pbit, len);
    repeat (5) @(negedge clk);
    check("en_restore_two_req", rd_req_cnt[0] - r0, 2);

    // Reset during D3 of 0x00, then 0x3C must follow intact
    push(0, 8'h00); push(0, 8'h3C);
    ok1 = 1'b0;
    for (int i = 0; i < 20 && !ok1; i++) begin
      @(negedge clk);
      if (txd[0] === 1'b0) ok1 = 1'b1;
    end
    check("rst_mid_start_seen", 32'(ok1), 32'd1);
    repeat (17) @(negedge clk);
    check("rst_mid_pre_txd", 32'(txd[0]), 32'd0);
    r0 = rd_req_cnt[0];
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("rst_mid_txd_async", 32'(txd[0]), 32'd1);
    check("rst_mid_busy_low", 32'(tx_busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    run_frame(0, 8'h3C, gap, pbit, len);
    repeat (5) @(negedge clk);
    check("rst_mid_single_req", rd_req_cnt[0] - r0, 1);

    // Protocol monitors
    check("no_underflow", underflow_cnt, 0);
    check("no_req_done_overlap", overlap_cnt, 0);
    check("req_single_cycle", wide_req_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter that drains the TX byte FIFO on its read side and serialises each byte onto `txd`. It replaces the simple always-read requester on the FIFO read port. It issues one read per frame, and only when the FIFO is non-empty and the line is idle. The block sits between the FIFO read port (`rd_req`/`rd_data`/`rd_empty`) and the board serial pin.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `PARITY_EN`, default 0: 1 inserts a parity bit after D7.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- Derived: `CLKS_PER_BIT` = `CLK_FREQ`/`BAUD_RATE` (integer division, must be ≥2). The bit counter is $clog2(`CLKS_PER_BIT`) wide.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `tx_en`  in  1  level enable. Sampled only in IDLE; a frame in progress always completes.
- `rd_empty`  in  1  FIFO empty flag.
- `rd_req`  out  1  FIFO read request, registered, exactly one cycle per frame.
- `rd_data`  in  8  FIFO read data, valid the cycle after the FIFO samples `rd_req` (non-FWFT, 1-cycle latency).
- `txd`  out  1  serial output, idle high.
- `tx_busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of the stop bit.

## Operation
- States: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - `txd`=1.
  - If `tx_en`=1 and `rd_empty`=0, then `rd_req`<=1 and go to REQ. Otherwise stay.
- REQ:
  - `rd_req` is high for exactly this cycle, and the FIFO samples it at the closing edge.
  - `rd_req`<=0, go to WAIT. `rd_empty` is not re-checked.
- WAIT:
  - `rd_data` is valid. Capture it into the shift register at the closing edge.
  - Compute parity = ^`rd_data` XOR `PARITY_ODD`.
  - Go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - Shift out LSB first, D0..D7, each bit held `CLKS_PER_BIT` cycles. A 3-bit index counts the bits.
  - After D7, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `txd`=parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP:
  - `txd`=1 for `CLKS_PER_BIT` cycles.
  - On the last cycle `frame_done`=1, then go to IDLE.
- Baud counter:
  - Runs 0..`CLKS_PER_BIT`-1 in START, DATA, PARITY and STOP.
  - Clears on every bit boundary and in IDLE, REQ and WAIT.
- `txd` is driven from a register: no combinational glitches on the pin.
- Reset values:
  - State IDLE, `txd`=1, `rd_req`=0, `tx_busy`=0, `frame_done`=0.
  - Shift register, counters and parity all 0.
- Reset asserted mid-frame:
  - `txd` returns to 1 immediately, asynchronously.
  - The byte already read is lost, and no extra read is issued.

## Timing
- Let `rd_empty` fall while in IDLE with `tx_en`=1, sampled at edge E0:
  - `rd_req` is high from E0 to E1.
  - WAIT is E1 to E2.
  - `txd` falls at E2.
- Frame length is (10 + `PARITY_EN`)·`CLKS_PER_BIT` cycles from the `txd` fall to the `frame_done` edge.
- Back-to-back frames with a non-empty FIFO:
  - The closing STOP edge enters IDLE, and the next `rd_req` is asserted at the following edge.
  - The next start bit begins 3 cycles after the end of the previous stop bit.
  - Sustained throughput is one byte per (10 + `PARITY_EN`)·`CLKS_PER_BIT` + 3 cycles.
- `rd_req` is never asserted while `rd_empty`=1 at the IDLE sampling edge. This prevents FIFO underflow.
- `rd_empty` rising during REQ or WAIT is legal (the last word was taken). The frame proceeds.
- `tx_en` falling during a frame has no effect until IDLE is re-entered.
- `frame_done` and `rd_req` are never high in the same cycle.

## Test plan
- Reset with the FIFO holding 0xA5 -> `txd`=1, `rd_req`=0 during reset. After release:
  - Exactly one `rd_req` pulse.
  - `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit `CLKS_PER_BIT` cycles.
  - `frame_done` pulses once.
- FIFO loaded with 0x00, 0xFF, 0x55 back-to-back (`CLKS_PER_BIT`=4 override) -> three frames decoded correctly, 3-cycle idle gap between frames, exactly 3 `rd_req` pulses.
- `PARITY_EN`=1:
  - `PARITY_ODD`=0 with 0x07 -> parity bit 1.
  - `PARITY_ODD`=1 with 0x07 -> parity bit 0.
  - Frame length is 11·`CLKS_PER_BIT` in both cases.
- `rd_empty` held high for 1000 cycles -> `rd_req`=0, `txd`=1 and `tx_busy`=0 throughout.
- `tx_en` dropped mid-frame with 2 bytes queued -> the current frame completes and no `rd_req` follows. `tx_en` raised again -> the second byte is sent.
- `rst_n` asserted during D3 -> `txd`=1 immediately and the state returns to IDLE. After release, the next FIFO byte is transmitted intact with a single `rd_req`.
